// File: rtl/sad_accum_tree_if.sv
// Bus bundle for sad_accum_tree: beat input, block result, min-tracking signals.
// Latency: none, this file only declares wires.
// Backpressure: none, the bus is valid-only and has no ready signal.
interface sad_accum_tree_if #(
  parameter int N_ELEM    = 64,
  parameter int IN_W      = 8,
  parameter int ACC_BEATS = 4,
  parameter int IDX_W     = 8
);
  localparam int T      = $clog2(N_ELEM) / 2;
  localparam int TREE_W = IN_W + 2 * T;
  localparam int SUM_W  = TREE_W + $clog2(ACC_BEATS);

  // beat side
  logic                     in_valid;
  logic                     in_first;
  logic [N_ELEM*IN_W-1:0]   ad;
  logic                     cand_clr;

  // result side
  logic                     out_valid;
  logic [SUM_W-1:0]         sum;
  logic                     blk_err;
  logic [SUM_W-1:0]         min_sum;
  logic [IDX_W-1:0]         min_idx;
  logic                     min_valid;

  modport master (
    output in_valid, in_first, ad, cand_clr,
    input  out_valid, sum, blk_err, min_sum, min_idx, min_valid
  );

  modport slave (
    input  in_valid, in_first, ad, cand_clr,
    output out_valid, sum, blk_err, min_sum, min_idx, min_valid
  );
endinterface

// File: rtl/sad_accum_tree.sv
// Pipelined radix-4 SAD reduction tree plus multi-beat block accumulator;
// min tracking is compiled in when SAD_MIN_TRACK_EN is defined.
// Latency: last beat at edge e -> sum/out_valid at edge e+T+1. Backpressure: none, one beat per cycle.
module sad_accum_tree #(
  parameter int N_ELEM    = 64,
  parameter int IN_W      = 8,
  parameter int ACC_BEATS = 4,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sad_accum_tree_if.slave   bus
);
  localparam int T      = $clog2(N_ELEM) / 2;
  localparam int TREE_W = IN_W + 2 * T;
  localparam int SUM_W  = TREE_W + $clog2(ACC_BEATS);
  localparam int CNT_W  = $clog2(ACC_BEATS + 1);

  // ---------------------------------------------------------------------
  // Reduction tree. Stage 0 captures the beat; stage s holds N_ELEM/4^s
  // words of IN_W+2s bits, each the sum of four adjacent words below it.
  // Data registers only load on a valid beat so idle cycles stay quiet.
  // ---------------------------------------------------------------------
  for (genvar s = 0; s <= T; s++) begin : g_stg
    localparam int NW = N_ELEM >> (2 * s);
    localparam int WW = IN_W + 2 * s;

    logic [NW*WW-1:0] r_dat;
    logic             r_vld;
    logic             r_first;

    if (s == 0) begin : g_in
      // capture the incoming beat and its tags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dat   <= '0;
          r_vld   <= 1'b0;
          r_first <= 1'b0;
        end else begin
          r_vld   <= bus.in_valid;
          r_first <= bus.in_first;
          if (bus.in_valid) r_dat <= bus.ad;
        end
      end
    end else begin : g_add
      localparam int PW = WW - 2;

      logic [4*NW*PW-1:0] w_prev;
      logic [NW*WW-1:0]   w_sum;

      assign w_prev = g_stg[s-1].r_dat;

      // four-input adders grouped as (a+b)+(c+d); widths are exact
      always_comb begin
        w_sum = '0;
        for (int j = 0; j < NW; j++) begin
          w_sum[j*WW +: WW] = (WW'(w_prev[(4*j)*PW +: PW])   + WW'(w_prev[(4*j+1)*PW +: PW]))
                            + (WW'(w_prev[(4*j+2)*PW +: PW]) + WW'(w_prev[(4*j+3)*PW +: PW]));
        end
      end

      // register the partial sums; tags follow the data one stage per cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dat   <= '0;
          r_vld   <= 1'b0;
          r_first <= 1'b0;
        end else begin
          r_vld   <= g_stg[s-1].r_vld;
          r_first <= g_stg[s-1].r_first;
          if (g_stg[s-1].r_vld) r_dat <= w_sum;
        end
      end
    end
  end

  logic [TREE_W-1:0] w_tree;
  logic              w_tree_vld;
  logic              w_tree_first;

  assign w_tree       = g_stg[T].r_dat;
  assign w_tree_vld   = g_stg[T].r_vld;
  assign w_tree_first = g_stg[T].r_first;

  // ---------------------------------------------------------------------
  // Block accumulator. IDLE waits for a first beat; ACC sums beats until
  // ACC_BEATS have been absorbed. A first beat always restarts the block.
  // ---------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SUM_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [SUM_W-1:0]  w_total;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_absorb;
  logic              w_err;
  logic              w_done;
  logic [SUM_W-1:0]  r_sum;
  logic              r_out_vld;
  logic              r_blk_err;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state: completion wins, otherwise any absorbed beat means ACC
  always_comb begin
    w_state_nxt = r_state;
    if (w_done)        w_state_nxt = ST_IDLE;
    else if (w_absorb) w_state_nxt = ST_ACC;
  end

  // per-beat decisions: absorb/drop, framing error, running total, completion
  always_comb begin
    w_absorb  = 1'b0;
    w_err     = 1'b0;
    w_total   = r_acc + SUM_W'(w_tree);
    w_cnt_nxt = r_cnt + 1'b1;
    if (w_tree_vld) begin
      if (w_tree_first) begin
        w_absorb  = 1'b1;
        w_err     = (r_state == ST_ACC);
        w_total   = SUM_W'(w_tree);
        w_cnt_nxt = CNT_W'(1);
      end else if (r_state == ST_ACC) begin
        w_absorb  = 1'b1;
      end else begin
        w_err     = 1'b1;
      end
    end
    w_done = w_absorb && (w_cnt_nxt == CNT_W'(ACC_BEATS));
  end

  // accumulator datapath and result/pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_out_vld <= 1'b0;
      r_blk_err <= 1'b0;
    end else begin
      r_out_vld <= w_done;
      r_blk_err <= w_err;
      if (w_absorb) begin
        r_acc <= w_total;
        r_cnt <= w_cnt_nxt;
      end
      if (w_done) r_sum <= w_total;
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.sum       = r_sum;
  assign bus.blk_err   = r_blk_err;

  // ---------------------------------------------------------------------
  // Optional minimum tracking over completed blocks.
  // ---------------------------------------------------------------------
`ifdef SAD_MIN_TRACK_EN
  logic [IDX_W-1:0] r_cand_idx;
  logic [IDX_W-1:0] r_min_idx;
  logic [SUM_W-1:0] r_min_sum;
  logic             r_min_vld;

  // number completed blocks and keep the strictly smallest; a clear that
  // lands on a completion restarts numbering with that block as index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_idx <= '0;
      r_min_idx  <= '0;
      r_min_sum  <= '0;
      r_min_vld  <= 1'b0;
    end else if (bus.cand_clr) begin
      r_cand_idx <= w_done ? IDX_W'(1) : '0;
      r_min_sum  <= w_done ? w_total : '0;
      r_min_idx  <= '0;
      r_min_vld  <= w_done;
    end else if (w_done) begin
      r_cand_idx <= r_cand_idx + 1'b1;
      if (!r_min_vld || (w_total < r_min_sum)) begin
        r_min_sum <= w_total;
        r_min_idx <= r_cand_idx;
        r_min_vld <= 1'b1;
      end
    end
  end

  assign bus.min_sum   = r_min_sum;
  assign bus.min_idx   = r_min_idx;
  assign bus.min_valid = r_min_vld;
`else
  logic w_unused_cand_clr;
  assign w_unused_cand_clr = bus.cand_clr;

  assign bus.min_sum   = '0;
  assign bus.min_idx   = '0;
  assign bus.min_valid = 1'b0;
`endif

endmodule
